// File: rtl/lsu_if.sv
// Load/store unit bus bundle: request and response handshakes plus the
// data-memory port.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The sender holds its payload stable
// while valid is high and ready is low.
//
// Modports:
//   slave  - the load/store unit (takes requests, returns responses,
//            drives the memory port).
//   master - the environment (issues requests, consumes responses,
//            supplies combinational memory read data).
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;

  logic [63:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_enable, mem_read_enable, mem_write_data,
    output mem_xfer_size
  );

  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_enable, mem_read_enable, mem_write_data,
    input  mem_xfer_size
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store at a time, checks size and
// bounds, performs the memory access and returns a response.
//
// Optional feature macro: LSU_MISALIGN_EN
//   defined   - misaligned requests are split into single-byte accesses
//               (state SPLIT, 3-bit byte counter).
//   undefined - misaligned requests are answered with resp_error=1 and
//               never touch memory.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - synchronous active-low reset
//   bus        - lsu_if.slave: request/response handshakes and memory port
//   dbg_state  - current FSM state (0 IDLE, 1 ACCESS, 2 SPLIT, 3 RESP)
//
// Every output is a register; the memory port address/data/size read as 0
// whenever neither enable is high.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  lsu_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // Registered request fields needed after the accept edge.
  logic       r_write;
  logic       r_signed;
  logic [3:0] r_size;

  // Request classification (valid only while bus.req_valid is high).
  logic        size_ok;
  logic [64:0] end_addr;
  logic        range_ok;
  logic        aligned;
  logic        req_err;

  assign size_ok  = (bus.req_size == 4'd1) || (bus.req_size == 4'd2) ||
                    (bus.req_size == 4'd4) || (bus.req_size == 4'd8);
  // 65-bit sum so an address near 2^64 cannot wrap into range.
  assign end_addr = {1'b0, bus.req_addr} + 65'(bus.req_size);
  assign range_ok = (end_addr <= 65'(MEM_BYTES));
  // size-1 as a 3-bit mask; size 8 gives 3'b111 because size[2:0] is 0.
  assign aligned  = ((bus.req_addr[2:0] & (bus.req_size[2:0] - 3'd1)) == 3'd0);

`ifdef LSU_MISALIGN_EN
  assign req_err = !size_ok || !range_ok;

  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  byte_cnt;
  logic [2:0]  cnt_next;
  logic [63:0] asm_data;
  logic [63:0] asm_next;
  logic        last_byte;

  always_comb begin
    cnt_next  = byte_cnt + 3'd1;
    last_byte = (byte_cnt == 3'(r_size - 4'd1));
    // Merge this cycle's read byte into the assembly register.
    asm_next  = asm_data;
    asm_next[{byte_cnt, 3'b000} +: 8] = bus.mem_read_data[7:0];
  end
`else
  assign req_err = !size_ok || !range_ok || !aligned;
`endif

  // Zero or sign extend a loaded value from sz bytes to 64 bits.
  function automatic logic [63:0] extend(input logic [63:0] d,
                                         input logic [3:0]  sz,
                                         input logic        sgn);
    logic [63:0] v;
    case (sz)
      4'd1:    v = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      4'd2:    v = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      4'd4:    v = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      r_write              <= 1'b0;
      r_signed             <= 1'b0;
      r_size               <= 4'd0;
      bus.req_ready        <= 1'b1;
      bus.resp_valid       <= 1'b0;
      bus.resp_error       <= 1'b0;
      bus.resp_rdata       <= 64'd0;
      bus.mem_address      <= 64'd0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_read_enable  <= 1'b0;
      bus.mem_write_data   <= 64'd0;
      bus.mem_xfer_size    <= 4'd0;
`ifdef LSU_MISALIGN_EN
      r_addr               <= 64'd0;
      r_wdata              <= 64'd0;
      byte_cnt             <= 3'd0;
      asm_data             <= 64'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write       <= bus.req_write;
            r_signed      <= bus.req_signed;
            r_size        <= bus.req_size;
            bus.req_ready <= 1'b0;
`ifdef LSU_MISALIGN_EN
            r_addr        <= bus.req_addr;
            r_wdata       <= bus.req_wdata;
`endif
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= 64'd0;
            end else if (aligned) begin
              state                <= ACCESS;
              bus.mem_address      <= bus.req_addr;
              bus.mem_xfer_size    <= bus.req_size;
              bus.mem_write_data   <= bus.req_wdata;
              bus.mem_write_enable <= bus.req_write;
              bus.mem_read_enable  <= !bus.req_write;
            end
`ifdef LSU_MISALIGN_EN
            else begin
              // First byte of the split sequence goes out right away.
              state                <= SPLIT;
              byte_cnt             <= 3'd0;
              asm_data             <= 64'd0;
              bus.mem_address      <= bus.req_addr;
              bus.mem_xfer_size    <= 4'd1;
              bus.mem_write_data   <= {56'd0, bus.req_wdata[7:0]};
              bus.mem_write_enable <= bus.req_write;
              bus.mem_read_enable  <= !bus.req_write;
            end
`endif
          end
        end

        ACCESS: begin
          state                <= RESP;
          bus.mem_address      <= 64'd0;
          bus.mem_write_enable <= 1'b0;
          bus.mem_read_enable  <= 1'b0;
          bus.mem_write_data   <= 64'd0;
          bus.mem_xfer_size    <= 4'd0;
          bus.resp_valid       <= 1'b1;
          bus.resp_error       <= 1'b0;
          bus.resp_rdata       <= r_write ? 64'd0
                                          : extend(bus.mem_read_data, r_size, r_signed);
        end

`ifdef LSU_MISALIGN_EN
        SPLIT: begin
          if (last_byte) begin
            state                <= RESP;
            byte_cnt             <= 3'd0;
            bus.mem_address      <= 64'd0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_write_data   <= 64'd0;
            bus.mem_xfer_size    <= 4'd0;
            bus.resp_valid       <= 1'b1;
            bus.resp_error       <= 1'b0;
            bus.resp_rdata       <= r_write ? 64'd0 : extend(asm_next, r_size, r_signed);
          end else begin
            byte_cnt           <= cnt_next;
            asm_data           <= asm_next;
            bus.mem_address    <= r_addr + 64'(cnt_next);
            bus.mem_write_data <= {56'd0, r_wdata[{cnt_next, 3'b000} +: 8]};
          end
        end
`endif

        RESP: begin
          // Outputs hold until the consumer takes the response.
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= 64'd0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a directed vector table, hand-written
// multi-cycle sequences (split write order, back-pressure, reset during a
// split store) and randomized requests checked against a byte-array model.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 1024;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  lsu_if lif ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (lif),
    .dbg_state (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- attached memory ----------------
  logic [7:0]  mem_bytes [MEM_BYTES];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          cyc = 0;
  logic [63:0] wr_log [$];   // {address, byte} per byte written
  int          wr_cyc [$];

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  always_comb begin
    lif.mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      if (lif.mem_address + 64'(i) < 64'(MEM_BYTES))
        lif.mem_read_data[8*i +: 8] = mem_bytes[int'(lif.mem_address) + i];
  end

  // The memory sits in the same reset domain: no writes while reset_n is low.
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] = init_byte(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n && lif.mem_write_enable) begin
        wr_cnt++;
        for (int i = 0; i < int'(lif.mem_xfer_size); i++) begin
          mem_bytes[int'(lif.mem_address) + i] = lif.mem_write_data[8*i +: 8];
          wr_log.push_back(((lif.mem_address + 64'(i)) << 8) | 64'(lif.mem_write_data[8*i +: 8]));
          wr_cyc.push_back(cyc);
        end
      end
      if (reset_n && lif.mem_read_enable) rd_cnt++;
    end
  end

  // Bus-level rules checked every cycle once out of reset.
  logic mon_on = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      check("mem_both_en", 64'(lif.mem_write_enable & lif.mem_read_enable), 64'd0);
      if (!lif.mem_write_enable && !lif.mem_read_enable)
        check("mem_idle_bus", lif.mem_address | lif.mem_write_data | 64'(lif.mem_xfer_size), 64'd0);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [MEM_BYTES];

  task automatic model(input logic w, input logic [63:0] a, input logic [3:0] s,
                       input logic sg, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat, output int acc);
    logic valid_sz, in_range, misal;
    logic [63:0] v;
    valid_sz = (s == 1) || (s == 2) || (s == 4) || (s == 8);
    in_range = valid_sz && (a <= 64'(MEM_BYTES)) && (a + 64'(s) <= 64'(MEM_BYTES));
    misal    = valid_sz && ((a % 64'(s)) != 0);
    er       = !in_range || (misal && !MIS_EN);
    rd = 0; lat = 1; acc = 0;
    if (!er) begin
      lat = misal ? int'(s) + 1 : 2;
      acc = misal ? int'(s) : 1;
      if (w) begin
        for (int i = 0; i < int'(s); i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < int'(s); i++) v = v | (64'(ref_bytes[int'(a) + i]) << (8 * i));
        if (sg && s < 8 && v[8*s-1]) v = v | (~64'd0 << (8 * s));
        rd = v;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input logic w, input logic [63:0] a, input logic [3:0] s,
                           input logic sg, input logic [63:0] wd);
    lif.req_write  = w;
    lif.req_addr   = a;
    lif.req_size   = s;
    lif.req_signed = sg;
    lif.req_wdata  = wd;
    lif.req_valid  = 1'b1;
  endtask

  // One full transaction; returns response, edges from accept to resp_valid,
  // and the number of memory accesses it caused.
  task automatic do_req(input logic w, input logic [63:0] a, input logic [3:0] s,
                        input logic sg, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat, output int acc);
    int g, wr0, rd0;
    rd = 0; er = 0; lat = 0; acc = 0;
    @(negedge clk);
    drive_req(w, a, s, sg, wd);
    g = 0;
    while (!lif.req_ready && g < 20) begin @(negedge clk); g++; end
    if (!lif.req_ready) begin
      check("req_ready_timeout", 64'(lif.req_ready), 64'd1);
      lif.req_valid = 1'b0;
    end else begin
      wr0 = wr_cnt; rd0 = rd_cnt;
      @(negedge clk);
      lif.req_valid = 1'b0;
      lat = 1;
      while (!lif.resp_valid && lat < 20) begin @(negedge clk); lat++; end
      if (!lif.resp_valid) check("resp_timeout", 64'(lif.resp_valid), 64'd1);
      rd  = lif.resp_rdata;
      er  = lif.resp_error;
      acc = (wr_cnt - wr0) + (rd_cnt - rd0);
      lif.resp_ready = 1'b1;
      @(negedge clk);
      lif.resp_ready = 1'b0;
      check("resp_drop", 64'(lif.resp_valid), 64'd0);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [3:0]  s;
    logic        sg;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_er;
    int          exp_acc;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [63:0] rd, mrd, hold_rd, exp_w;
    logic        er, mer;
    int          lat, mlat, acc, macc, g, log0, nbad;
    logic [63:0] exp_q [$];
    logic [7:0]  orig [8];

    lif.req_valid = 0; lif.req_write = 0; lif.req_addr = 0; lif.req_size = 0;
    lif.req_signed = 0; lif.req_wdata = 0; lif.resp_ready = 0;
    for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = init_byte(i);

    vecs[0]  = '{1'b1, 64'h10, 4'd8, 1'b0, 64'h1122334455667788, 64'h0, 1'b0, 1};
    vecs[1]  = '{1'b0, 64'h10, 4'd8, 1'b1, 64'h0, 64'h1122334455667788, 1'b0, 1};
    vecs[2]  = '{1'b1, 64'h21, 4'd1, 1'b0, 64'h80, 64'h0, 1'b0, 1};
    vecs[3]  = '{1'b0, 64'h21, 4'd1, 1'b1, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 1};
    vecs[4]  = '{1'b0, 64'h21, 4'd1, 1'b0, 64'h0, 64'h0000000000000080, 1'b0, 1};
    vecs[5]  = '{1'b1, 64'h03, 4'd4, 1'b0, 64'hAABBCCDD, 64'h0, !MIS_EN, MIS_EN ? 4 : 0};
    vecs[6]  = '{1'b0, 64'h03, 4'd4, 1'b0, 64'h0, MIS_EN ? 64'hAABBCCDD : 64'h0, !MIS_EN,
                 MIS_EN ? 4 : 0};
    vecs[7]  = '{1'b0, 64'd1020, 4'd8, 1'b0, 64'h0, 64'h0, 1'b1, 0};
    vecs[8]  = '{1'b0, 64'h0, 4'd3, 1'b0, 64'h0, 64'h0, 1'b1, 0};
    vecs[9]  = '{1'b1, 64'd1022, 4'd2, 1'b0, 64'hBEEF, 64'h0, 1'b0, 1};
    vecs[10] = '{1'b0, 64'd1022, 4'd2, 1'b1, 64'h0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 1};
    vecs[11] = '{1'b0, 64'd1024, 4'd1, 1'b0, 64'h0, 64'h0, 1'b1, 0};
    vecs[12] = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd4, 1'b0, 64'h0, 64'h0, 1'b1, 0};

    // ---- reset state ----
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(lif.req_ready), 64'd1);
    check("rst_resp_valid", 64'(lif.resp_valid), 64'd0);
    check("rst_resp_error", 64'(lif.resp_error), 64'd0);
    check("rst_resp_rdata", lif.resp_rdata, 64'd0);
    check("rst_mem_en", 64'({lif.mem_write_enable, lif.mem_read_enable}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // ---- table ----
    for (int k = 0; k < 13; k++) begin
      model(vecs[k].w, vecs[k].a, vecs[k].s, vecs[k].sg, vecs[k].wd, mrd, mer, mlat, macc);
      do_req(vecs[k].w, vecs[k].a, vecs[k].s, vecs[k].sg, vecs[k].wd, rd, er, lat, acc);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      check($sformatf("vec%0d_error", k), 64'(er), 64'(vecs[k].exp_er));
      check($sformatf("vec%0d_accesses", k), 64'(acc), 64'(vecs[k].exp_acc));
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'(mlat));
    end

`ifdef LSU_MISALIGN_EN
    // ---- split store: byte order, addresses, consecutive cycles ----
    log0 = wr_log.size();
    model(1'b1, 64'h03, 4'd4, 1'b0, 64'hAABBCCDD, mrd, mer, mlat, macc);
    do_req(1'b1, 64'h03, 4'd4, 1'b0, 64'hAABBCCDD, rd, er, lat, acc);
    exp_w = 64'hAABBCCDD;
    for (int i = 0; i < 4; i++) exp_q.push_back((64'(3 + i) << 8) | 64'(exp_w[8*i +: 8]));
    check("split_wr_count", 64'(wr_log.size() - log0), 64'd4);
    for (int i = 0; i < 4 && log0 + i < wr_log.size(); i++) begin
      check($sformatf("split_wr%0d", i), wr_log[log0 + i], exp_q[i]);
      if (i > 0)
        check($sformatf("split_cyc%0d", i), 64'(wr_cyc[log0 + i] - wr_cyc[log0 + i - 1]), 64'd1);
    end
`endif

    // ---- back-pressure: response held for 5 cycles ----
    @(negedge clk);
    drive_req(1'b0, 64'h10, 4'd8, 1'b0, 64'h0);
    @(negedge clk);
    lif.req_valid = 1'b0;
    g = 0;
    while (!lif.resp_valid && g < 20) begin @(negedge clk); g++; end
    check("bp_resp_valid", 64'(lif.resp_valid), 64'd1);
    hold_rd = 64'h1122334455667788;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", i), 64'(lif.resp_valid), 64'd1);
      check($sformatf("bp_rdata_c%0d", i), lif.resp_rdata, hold_rd);
      check($sformatf("bp_error_c%0d", i), 64'(lif.resp_error), 64'd0);
      check($sformatf("bp_ready_c%0d", i), 64'(lif.req_ready), 64'd0);
    end
    lif.resp_ready = 1'b1;
    @(negedge clk);
    lif.resp_ready = 1'b0;
    check("bp_release_valid", 64'(lif.resp_valid), 64'd0);
    check("bp_release_ready", 64'(lif.req_ready), 64'd1);

`ifdef LSU_MISALIGN_EN
    // ---- reset during a size-8 split store after three bytes ----
    for (int i = 0; i < 8; i++) orig[i] = ref_bytes[16'h41 + i];
    @(negedge clk);
    drive_req(1'b1, 64'h41, 4'd8, 1'b0, 64'h0807060504030201);
    @(negedge clk);
    lif.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    mon_on  = 1'b0;
    @(negedge clk);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_req_ready", 64'(lif.req_ready), 64'd1);
    check("abort_resp_valid", 64'(lif.resp_valid), 64'd0);
    check("abort_mem_en", 64'({lif.mem_write_enable, lif.mem_read_enable}), 64'd0);
    reset_n = 1'b1;
    mon_on  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_resp%0d", i), 64'(lif.resp_valid), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("abort_byte%0d", i), 64'(mem_bytes[16'h41 + i]),
            i < 3 ? 64'(i + 1) : 64'(orig[i]));
      if (i < 3) ref_bytes[16'h41 + i] = 8'(i + 1);
    end
`endif

    // ---- randomized requests vs model ----
    for (int t = 0; t < 250; t++) begin
      logic        w, sg;
      logic [63:0] a, wd;
      logic [3:0]  s;
      int          r;
      logic [3:0]  sizes [10];
      sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
      r  = $urandom_range(0, 9);
      s  = (r == 9 && $urandom_range(0, 1) == 1) ? 4'd15 : sizes[$urandom_range(0, 9)];
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = {32'($urandom), 32'($urandom)};
      if (r == 0)      a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
      else if (r == 1) a = 64'(MEM_BYTES - 8 + $urandom_range(0, 15));
      else if (r < 6)  a = 64'($urandom_range(0, 63));
      else             a = 64'($urandom_range(0, MEM_BYTES - 1));
      model(w, a, s, sg, wd, mrd, mer, mlat, macc);
      do_req(w, a, s, sg, wd, rd, er, lat, acc);
      check($sformatf("rnd%0d_rdata", t), rd, mrd);
      check($sformatf("rnd%0d_error", t), 64'(er), 64'(mer));
      check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(mlat));
      check($sformatf("rnd%0d_accesses", t), 64'(acc), 64'(macc));
    end

    // ---- whole memory image vs model ----
    @(negedge clk);
    nbad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem_bytes[i] !== ref_bytes[i]) nbad++;
    check("mem_image_bad_bytes", 64'(nbad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
